// File: rtl/branch_cond_unit.sv
// Branch condition unit: holds the ALU status flags and evaluates one of eight
// branch conditions per eval strobe. The result comes out as a one-cycle
// registered pc_write_cond pulse. Saturating taken/not-taken counters
// are kept for debug readout.
module branch_cond_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flags_we,
  input  logic             zero_in,
  input  logic             gt_in,
  input  logic             lt_in,
  input  logic             eq_in,
  input  logic [2:0]       cond_sel,
  input  logic             eval,
  input  logic             cnt_clr,
  output logic             pc_write_cond,
  output logic             done,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  localparam int unsigned FLAG_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Condition codes; the low four match the legacy 2-bit select
  localparam logic [2:0] COND_BNE    = 3'b000;
  localparam logic [2:0] COND_BEQ    = 3'b001;
  localparam logic [2:0] COND_BGT    = 3'b010;
  localparam logic [2:0] COND_BLE    = 3'b011;
  localparam logic [2:0] COND_BLT    = 3'b100;
  localparam logic [2:0] COND_BGE    = 3'b101;
  localparam logic [2:0] COND_ALWAYS = 3'b110;
  localparam logic [2:0] COND_NEVER  = 3'b111;

  logic [FLAG_W-1:0] flags_in_c;
  logic [FLAG_W-1:0] eff_flags_c;
  logic              flag_z_c;
  logic              flag_gt_c;
  logic              flag_lt_c;
  logic              flag_eq_c;
  logic              cond_c;
  logic              taken_c;
  logic              not_taken_c;

  assign flags_in_c = {zero_in, gt_in, lt_in, eq_in};

  // Forward incoming flags to an eval in the same cycle as their capture
  always_comb begin
    eff_flags_c = flags_q;
    if (flags_we && eval) begin
      eff_flags_c = flags_in_c;
    end
  end

  assign flag_z_c  = eff_flags_c[3];
  assign flag_gt_c = eff_flags_c[2];
  assign flag_lt_c = eff_flags_c[1];
  assign flag_eq_c = eff_flags_c[0];

  // Condition select against the effective flags
  always_comb begin
    cond_c = 1'b0;
    unique case (cond_sel)
      COND_BNE:    cond_c = ~flag_z_c;
      COND_BEQ:    cond_c = flag_z_c;
      COND_BGT:    cond_c = flag_gt_c;
      COND_BLE:    cond_c = flag_lt_c | flag_eq_c;
      COND_BLT:    cond_c = flag_lt_c;
      COND_BGE:    cond_c = flag_gt_c | flag_eq_c;
      COND_ALWAYS: cond_c = 1'b1;
      COND_NEVER:  cond_c = 1'b0;
      default:     cond_c = 1'b0;
    endcase
  end

  // Gate by eval so an undefined select while idle cannot propagate
  assign taken_c     = eval & cond_c;
  assign not_taken_c = eval & ~cond_c;

  // Flag register, result pulse and statistics counters
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q       <= '0;
      done          <= 1'b0;
      pc_write_cond <= 1'b0;
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
    end else begin
      if (flags_we) begin
        flags_q <= flags_in_c;
      end
      done          <= eval;
      pc_write_cond <= taken_c;
      if (cnt_clr) begin
        taken_cnt     <= '0;
        not_taken_cnt <= '0;
      end else begin
        if (taken_c && (taken_cnt != CNT_MAX)) begin
          taken_cnt <= taken_cnt + CNT_W'(1);
        end
        if (not_taken_c && (not_taken_cnt != CNT_MAX)) begin
          not_taken_cnt <= not_taken_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
